// File: rtl/data_mem_responder.sv
// Memory-side responder for CPU load/store requests: one request at a time,
// programmable wait states, little-endian byte/half/word access to a word array.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic        MEM_req_valid,
  output logic        MEM_req_ready,
  input  logic        MEM_req_write,
  input  logic [31:0] MEM_req_address,
  input  logic [31:0] MEM_req_wdata,
  input  logic [2:0]  MEM_req_funct3,
  output logic        MEM_resp_valid,
  input  logic        MEM_resp_ready,
  output logic [31:0] MEM_resp_rdata,
  output logic        MEM_resp_error
);

  localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_CYCLES);

  // ACCESS is the single cycle whose closing edge commits stores and registers the response.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_error_q, resp_error_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0]      offset;
  logic [IDX_W-1:0] word_idx;
  logic             in_range;
  logic             misaligned;
  logic             bad_funct3;
  logic             access_err;
  logic [31:0]      rd_word;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic             sign_ext;
  logic [31:0]      load_data;
  logic [3:0]       byte_en;
  logic [31:0]      wr_lanes;
  logic [31:0]      mem_word_d;
  logic             mem_we;

  assign MEM_req_ready  = (state_q == ST_IDLE);
  assign MEM_resp_valid = resp_valid_q;
  assign MEM_resp_rdata = resp_rdata_q;
  assign MEM_resp_error = resp_error_q;

  // Address decode, error classification, load extraction and store lane merge.
  always_comb begin
    offset     = addr_q - BASE_ADDR;
    word_idx   = offset[IDX_W+1:2];
    in_range   = (addr_q >= BASE_ADDR) && (offset < SPAN_BYTES);
    misaligned = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                 ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
    if (write_q) begin
      bad_funct3 = funct3_q[2] || (funct3_q[1:0] == 2'b11);
    end else begin
      bad_funct3 = (funct3_q == 3'b011) || (funct3_q[2:1] == 2'b11);
    end
    access_err = !in_range || misaligned || bad_funct3;

    rd_word  = in_range ? mem_q[word_idx] : 32'h0;
    rd_byte  = rd_word[{addr_q[1:0], 3'b000} +: 8];
    rd_half  = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    sign_ext = !funct3_q[2];

    case (funct3_q[1:0])
      2'b00:   load_data = {{24{sign_ext & rd_byte[7]}}, rd_byte};
      2'b01:   load_data = {{16{sign_ext & rd_half[15]}}, rd_half};
      default: load_data = rd_word;
    endcase

    case (funct3_q[1:0])
      2'b00: begin
        byte_en  = 4'b0001 << addr_q[1:0];
        wr_lanes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        byte_en  = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{wdata_q[15:0]}};
      end
      default: begin
        byte_en  = 4'b1111;
        wr_lanes = wdata_q;
      end
    endcase

    for (int b = 0; b < 4; b++) begin
      mem_word_d[8*b +: 8] = byte_en[b] ? wr_lanes[8*b +: 8] : rd_word[8*b +: 8];
    end

    mem_we = (state_q == ST_ACCESS) && write_q && !access_err;
  end

  // Next-state, request capture and response registration.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    funct3_d     = funct3_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_error_d = resp_error_q;

    case (state_q)
      ST_IDLE: begin
        if (MEM_req_valid) begin
          write_d  = MEM_req_write;
          addr_d   = MEM_req_address;
          wdata_d  = MEM_req_wdata;
          funct3_d = MEM_req_funct3;
          cnt_d    = WAIT_INIT;
          state_d  = (WAIT_INIT == 4'd0) ? ST_ACCESS : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_error_d = access_err;
        resp_rdata_d = (access_err || write_q) ? 32'h0 : load_data;
      end
      ST_RESP: begin
        if (MEM_resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          resp_rdata_d = 32'h0;
          resp_error_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and response registers; reset drops any in-flight transaction.
  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      write_q      <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      funct3_q     <= 3'b000;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      funct3_q     <= funct3_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
    end
  end

  // Word array; contents survive reset, stores commit on the access edge only.
  always_ff @(posedge SYS_clk) begin
    if (mem_we) begin
      mem_q[word_idx] <= mem_word_d;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: instance 0 uses 2 wait states, instance 1 uses none.
module tb_data_mem_responder;

  localparam logic [31:0] BASE  = 32'h0000_2000;
  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [2:0]  req_f3     [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_error [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(2)) dut (
    .SYS_clk(clk), .SYS_reset(rst_n),
    .MEM_req_valid(req_valid[0]), .MEM_req_ready(req_ready[0]),
    .MEM_req_write(req_write[0]), .MEM_req_address(req_addr[0]),
    .MEM_req_wdata(req_wdata[0]), .MEM_req_funct3(req_f3[0]),
    .MEM_resp_valid(resp_valid[0]), .MEM_resp_ready(resp_ready[0]),
    .MEM_resp_rdata(resp_rdata[0]), .MEM_resp_error(resp_error[0])
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut0 (
    .SYS_clk(clk), .SYS_reset(rst_n),
    .MEM_req_valid(req_valid[1]), .MEM_req_ready(req_ready[1]),
    .MEM_req_write(req_write[1]), .MEM_req_address(req_addr[1]),
    .MEM_req_wdata(req_wdata[1]), .MEM_req_funct3(req_f3[1]),
    .MEM_resp_valid(resp_valid[1]), .MEM_resp_ready(resp_ready[1]),
    .MEM_resp_rdata(resp_rdata[1]), .MEM_resp_error(resp_error[1])
  );

  // One full transaction: present, accept, count edges to response, then handshake.
  task automatic do_txn(input int s, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] f3,
                        output logic [31:0] rd, output logic er, output int lat,
                        output logic acc);
    acc          = req_ready[s];
    req_valid[s] = 1'b1;
    req_write[s] = wr;
    req_addr[s]  = a;
    req_wdata[s] = wd;
    req_f3[s]    = f3;
    @(posedge clk); #1;
    req_valid[s] = 1'b0;
    rd  = 32'h0;
    er  = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!resp_valid[s] && lat < 40);
    if (!resp_valid[s]) begin
      lat = -1;
      return;
    end
    rd = resp_rdata[s];
    er = resp_error[s];
    resp_ready[s] = 1'b1;
    @(posedge clk); #1;
    resp_ready[s] = 1'b0;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      checks++;
      if ({req_ready[s], resp_valid[s], resp_error[s], resp_rdata[s]} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
        errors++;
        $display("FAIL reset_state inst %0d got rdy=%b vld=%b err=%b rd=%h want 1 0 0 00000000",
                 s, req_ready[s], resp_valid[s], resp_error[s], resp_rdata[s]);
      end
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat; logic acc;
    do_txn(0, 1'b1, BASE + 32'h10, 32'hDEADBEEF, 3'b010, rd, er, lat, acc);
    checks++;
    if (lat !== 3 || acc !== 1'b1 || er !== 1'b0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL sw_basic got lat=%0d acc=%b err=%b rd=%h want 3 1 0 00000000", lat, acc, er, rd);
    end
    do_txn(0, 1'b0, BASE + 32'h10, 32'h0, 3'b010, rd, er, lat, acc);
    checks++;
    if (lat !== 3 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL lw_basic got lat=%0d err=%b rd=%h want 3 0 deadbeef", lat, er, rd);
    end
  endtask

  task automatic test_subword();
    logic [31:0] rd; logic er; int lat; logic acc;
    logic [31:0] exp_v [4];
    logic [2:0]  f3_v  [4];
    logic [31:0] ad_v  [4];
    exp_v = '{32'hFFFFFF80, 32'h00000080, 32'h80ADBEEF, 32'hFFFF80AD};
    f3_v  = '{3'b000, 3'b100, 3'b010, 3'b001};
    ad_v  = '{BASE + 32'h13, BASE + 32'h13, BASE + 32'h10, BASE + 32'h12};
    do_txn(0, 1'b1, BASE + 32'h13, 32'h00000080, 3'b000, rd, er, lat, acc);
    checks++;
    if (er !== 1'b0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL sb_store got err=%b rd=%h want 0 00000000", er, rd);
    end
    for (int i = 0; i < 4; i++) begin
      do_txn(0, 1'b0, ad_v[i], 32'h0, f3_v[i], rd, er, lat, acc);
      checks++;
      if (er !== 1'b0 || rd !== exp_v[i]) begin
        errors++;
        $display("FAIL subword_load_%0d got err=%b rd=%h want 0 %h", i, er, rd, exp_v[i]);
      end
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic er; int lat; logic acc;
    do_txn(0, 1'b0, BASE + 32'h11, 32'h0, 3'b001, rd, er, lat, acc);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL lh_misaligned got err=%b rd=%h want 1 00000000", er, rd);
    end
    do_txn(0, 1'b1, BASE + 32'h12, 32'h55555555, 3'b010, rd, er, lat, acc);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL sw_misaligned got err=%b rd=%h want 1 00000000", er, rd);
    end
    do_txn(0, 1'b0, BASE + 32'h10, 32'h0, 3'b010, rd, er, lat, acc);
    checks++;
    if (er !== 1'b0 || rd !== 32'h80ADBEEF) begin
      errors++;
      $display("FAIL misaligned_no_write got err=%b rd=%h want 0 80adbeef", er, rd);
    end
  endtask

  task automatic test_range();
    logic [31:0] rd; logic er; int lat; logic acc;
    logic [31:0] ad_v [4];
    logic [2:0]  f3_v [4];
    logic        wr_v [4];
    ad_v = '{BASE + 32'(DEPTH * 4), BASE - 32'h4, BASE + 32'h10, BASE + 32'h10};
    f3_v = '{3'b010, 3'b010, 3'b011, 3'b100};
    wr_v = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      do_txn(0, wr_v[i], ad_v[i], 32'h0BAD0BAD, f3_v[i], rd, er, lat, acc);
      checks++;
      if (er !== 1'b1 || rd !== 32'h0) begin
        errors++;
        $display("FAIL range_err_%0d got err=%b rd=%h want 1 00000000", i, er, rd);
      end
    end
    do_txn(0, 1'b0, BASE + 32'(DEPTH * 4) - 32'h4, 32'h0, 3'b010, rd, er, lat, acc);
    checks++;
    if (er !== 1'b0) begin
      errors++;
      $display("FAIL last_word got err=%b want 0", er);
    end
    do_txn(0, 1'b0, BASE + 32'h10, 32'h0, 3'b010, rd, er, lat, acc);
    checks++;
    if (er !== 1'b0 || rd !== 32'h80ADBEEF) begin
      errors++;
      $display("FAIL bad_store_no_write got err=%b rd=%h want 0 80adbeef", er, rd);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat; logic acc;
    int n = 0;
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = BASE + 32'h10; req_f3[0] = 3'b010;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    while (!resp_valid[0] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (resp_valid[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_resp_timeout got vld=%b want 1", resp_valid[0]);
    end
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_wdata[0] = 32'h11111111;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({resp_valid[0], req_ready[0], resp_error[0], resp_rdata[0]} !== {1'b1, 1'b0, 1'b0, 32'h80ADBEEF}) begin
        errors++;
        $display("FAIL bp_hold_%0d got vld=%b rdy=%b err=%b rd=%h want 1 0 0 80adbeef",
                 c, resp_valid[0], req_ready[0], resp_error[0], resp_rdata[0]);
      end
    end
    req_valid[0]  = 1'b0;
    resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    resp_ready[0] = 1'b0;
    checks++;
    if ({req_ready[0], resp_valid[0], resp_error[0], resp_rdata[0]} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL bp_release got rdy=%b vld=%b err=%b rd=%h want 1 0 0 00000000",
               req_ready[0], resp_valid[0], resp_error[0], resp_rdata[0]);
    end
    do_txn(0, 1'b0, BASE + 32'h10, 32'h0, 3'b010, rd, er, lat, acc);
    checks++;
    if (er !== 1'b0 || rd !== 32'h80ADBEEF) begin
      errors++;
      $display("FAIL bp_ignored_req got err=%b rd=%h want 0 80adbeef", er, rd);
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] rd; logic er; int lat; logic acc;
    do_txn(0, 1'b1, BASE + 32'h20, 32'hCAFEF00D, 3'b010, rd, er, lat, acc);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = BASE + 32'h20;
    req_wdata[0] = 32'h12345678; req_f3[0] = 3'b010;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL midop_reset got vld=%b rdy=%b want 0 1", resp_valid[0], req_ready[0]);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_idle got vld=%b rdy=%b want 0 1", resp_valid[0], req_ready[0]);
    end
    do_txn(0, 1'b0, BASE + 32'h20, 32'h0, 3'b010, rd, er, lat, acc);
    checks++;
    if (er !== 1'b0 || rd !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL dropped_store got err=%b rd=%h want 0 cafef00d", er, rd);
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] rd; logic er; int lat; logic acc;
    logic [31:0] m [16];
    logic [31:0] a, wd, w, exp_rd;
    logic [7:0]  b8;
    logic [15:0] h16;
    int idx, op, o;
    for (int i = 0; i < 16; i++) begin
      m[i] = 32'hA5A5_0000 ^ (32'(i) * 32'h0103_0507);
      do_txn(1, 1'b1, BASE + 32'h100 + 32'(i * 4), m[i], 3'b010, rd, er, lat, acc);
      if (i == 0) begin
        checks++;
        if (lat !== 1 || acc !== 1'b1 || er !== 1'b0) begin
          errors++;
          $display("FAIL zw_latency got lat=%0d acc=%b err=%b want 1 1 0", lat, acc, er);
        end
      end
    end
    for (int t = 0; t < 100; t++) begin
      idx = int'($urandom_range(0, 15));
      op  = int'($urandom_range(0, 7));
      wd  = $urandom;
      o   = int'($urandom_range(0, 3));
      w   = m[idx];
      exp_rd = 32'h0;
      case (op)
        1, 4, 5: o = o & 2;
        0, 3:    o = 0;
        default: ;
      endcase
      a = BASE + 32'h100 + 32'(idx * 4 + o);
      case (op)
        0: begin do_txn(1, 1'b1, a, wd, 3'b010, rd, er, lat, acc); m[idx] = wd; end
        1: begin
          do_txn(1, 1'b1, a, wd, 3'b001, rd, er, lat, acc);
          m[idx] = (w & ~(32'h0000FFFF << (8 * o))) | ((wd & 32'h0000FFFF) << (8 * o));
        end
        2: begin
          do_txn(1, 1'b1, a, wd, 3'b000, rd, er, lat, acc);
          m[idx] = (w & ~(32'h000000FF << (8 * o))) | ((wd & 32'h000000FF) << (8 * o));
        end
        3: begin do_txn(1, 1'b0, a, wd, 3'b010, rd, er, lat, acc); exp_rd = w; end
        4: begin
          do_txn(1, 1'b0, a, wd, 3'b001, rd, er, lat, acc);
          h16 = 16'(w >> (8 * o));
          exp_rd = {{16{h16[15]}}, h16};
        end
        5: begin
          do_txn(1, 1'b0, a, wd, 3'b101, rd, er, lat, acc);
          exp_rd = 32'(16'(w >> (8 * o)));
        end
        6: begin
          do_txn(1, 1'b0, a, wd, 3'b000, rd, er, lat, acc);
          b8 = 8'(w >> (8 * o));
          exp_rd = {{24{b8[7]}}, b8};
        end
        default: begin
          do_txn(1, 1'b0, a, wd, 3'b100, rd, er, lat, acc);
          exp_rd = 32'(8'(w >> (8 * o)));
        end
      endcase
      checks++;
      if (lat !== 1 || acc !== 1'b1 || er !== 1'b0 || rd !== exp_rd) begin
        errors++;
        $display("FAIL zw_random_%0d op=%0d addr=%h got lat=%0d acc=%b err=%b rd=%h want 1 1 0 %h",
                 t, op, a, lat, acc, er, rd, exp_rd);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0; req_write[s] = 1'b0; req_addr[s] = 32'h0;
      req_wdata[s] = 32'h0; req_f3[s] = 3'b000; resp_ready[s] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_store_load();
    test_subword();
    test_misaligned();
    test_range();
    test_backpressure();
    test_reset_midop();
    test_zero_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
